pipeline_stall_ctrl: RTL and testbench

- Sequences the five-stage pipeline register enables: PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Resolves three stall sources: load-use hazards, HI/LO dependencies on an in-flight multi-cycle divide, and wait states on data-memory accesses in MEM.
- Drives the `ena` inputs of every stage register and the ID/EXE bubble insert.

---
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall controller for the five-stage pipeline.
// Produces the register enables for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB,
// and the ID/EXE bubble insert. Three stall sources are handled, highest
// priority first: data-memory wait states, load-use hazards, and HI/LO
// dependencies on a divide that is still in flight.
module pipeline_stall_ctrl #(
    parameter int DMEM_WAIT  = 0,   // extra cycles a DMEM access holds MEM
    parameter int DIV_CYCLES = 32   // divider busy time, 1..63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_hilo_dep,
    input  logic       exe_is_load,
    input  logic [4:0] exe_GPR_waddr,
    input  logic       exe_div_start,
    input  logic       mem_dmem_access,
    output logic       pc_ena,
    output logic       if_id_ena,
    output logic       id_exe_ena,
    output logic       id_exe_bubble,
    output logic       exe_mem_ena,
    output logic       mem_wb_ena,
    output logic       div_busy,
    output logic [1:0] stall_cause
);

    // The wait counter only has to hold DMEM_WAIT-1.
    localparam int WCW = (DMEM_WAIT > 1) ? $clog2(DMEM_WAIT) : 1;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic [5:0]     div_cnt, div_cnt_nxt;
    logic           lu, hl, run_ok;

    // Load-use: ID reads the register a load in EXE is about to write.
    assign lu = exe_is_load && (exe_GPR_waddr != 5'd0) &&
                ((id_uses_rs && (id_rs_addr == exe_GPR_waddr)) ||
                 (id_uses_rt && (id_rt_addr == exe_GPR_waddr)));

    // HI/LO access in ID while the divider has not produced its result.
    assign hl = id_hilo_dep && div_busy;

    // Next-state and enable decode; mem wait outranks the ID hazards.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        run_ok        = 1'b0;
        pc_ena        = 1'b0;
        if_id_ena     = 1'b0;
        id_exe_ena    = 1'b0;
        id_exe_bubble = 1'b0;
        exe_mem_ena   = 1'b0;
        mem_wb_ena    = 1'b0;
        stall_cause   = 2'd0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (mem_dmem_access && (DMEM_WAIT > 0)) begin
                        stall_cause  = 2'd3;
                        wait_cnt_nxt = WCW'(DMEM_WAIT - 1);
                        state_nxt    = MEM_WAIT;
                    end else begin
                        run_ok = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // mem_dmem_access is ignored here: the release cycle
                    // must not re-trigger on the same access.
                    if (wait_cnt != '0) begin
                        stall_cause  = 2'd3;
                        wait_cnt_nxt = wait_cnt - 1'b1;
                    end else begin
                        run_ok    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
            if (run_ok) begin
                id_exe_ena  = 1'b1;
                exe_mem_ena = 1'b1;
                mem_wb_ena  = 1'b1;
                if (lu || hl) begin
                    id_exe_bubble = 1'b1;
                    stall_cause   = lu ? 2'd1 : 2'd2;
                end else begin
                    pc_ena    = 1'b1;
                    if_id_ena = 1'b1;
                end
            end
        end
    end

    // Divider countdown; only a div actually leaving EXE (re)starts it.
    always_comb begin
        div_cnt_nxt = div_cnt;
        if (exe_div_start && exe_mem_ena)
            div_cnt_nxt = 6'(DIV_CYCLES);
        else if (div_cnt != 6'd0)
            div_cnt_nxt = div_cnt - 6'd1;
    end

    // State, counters and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            div_cnt  <= 6'd0;
            div_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            div_cnt  <= div_cnt_nxt;
            div_busy <= (div_cnt_nxt != 6'd0);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Two instances share stimulus:
// u_a with DMEM_WAIT=2, u_b with DMEM_WAIT=1, both DIV_CYCLES=4.
// Expected output vectors are queued as each step is driven and checked
// on the following falling edge.
module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs_addr, id_rt_addr, exe_GPR_waddr;
    logic       id_uses_rs, id_uses_rt, id_hilo_dep;
    logic       exe_is_load, exe_div_start, mem_dmem_access;

    logic       a_pc, a_ifid, a_idexe, a_bub, a_em, a_mw, a_busy;
    logic [1:0] a_cause;
    logic       b_pc, b_ifid, b_idexe, b_bub, b_em, b_mw, b_busy;
    logic [1:0] b_cause;

    logic [8:0] obs_a, obs_b;
    assign obs_a = {a_pc, a_ifid, a_idexe, a_bub, a_em, a_mw, a_busy, a_cause};
    assign obs_b = {b_pc, b_ifid, b_idexe, b_bub, b_em, b_mw, b_busy, b_cause};

    pipeline_stall_ctrl #(.DMEM_WAIT(2), .DIV_CYCLES(4)) u_a (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hilo_dep(id_hilo_dep), .exe_is_load(exe_is_load),
        .exe_GPR_waddr(exe_GPR_waddr), .exe_div_start(exe_div_start),
        .mem_dmem_access(mem_dmem_access),
        .pc_ena(a_pc), .if_id_ena(a_ifid), .id_exe_ena(a_idexe),
        .id_exe_bubble(a_bub), .exe_mem_ena(a_em), .mem_wb_ena(a_mw),
        .div_busy(a_busy), .stall_cause(a_cause)
    );

    pipeline_stall_ctrl #(.DMEM_WAIT(1), .DIV_CYCLES(4)) u_b (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_hilo_dep(id_hilo_dep), .exe_is_load(exe_is_load),
        .exe_GPR_waddr(exe_GPR_waddr), .exe_div_start(exe_div_start),
        .mem_dmem_access(mem_dmem_access),
        .pc_ena(b_pc), .if_id_ena(b_ifid), .id_exe_ena(b_idexe),
        .id_exe_bubble(b_bub), .exe_mem_ena(b_em), .mem_wb_ena(b_mw),
        .div_busy(b_busy), .stall_cause(b_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         inst_b;
        logic [8:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;

    // Vector order: pc, if_id, id_exe, bubble, exe_mem, mem_wb, busy, cause
    function automatic logic [8:0] pk(bit pc, bit fi, bit ie, bit bb, bit em,
                                      bit mw, bit busy, logic [1:0] c);
        return {pc, fi, ie, bb, em, mw, busy, c};
    endfunction

    function automatic logic [8:0] v_run(bit busy);
        return pk(1, 1, 1, 0, 1, 1, busy, 2'd0);
    endfunction

    function automatic logic [8:0] v_stall(logic [1:0] c, bit busy);
        return pk(0, 0, 1, 1, 1, 1, busy, c);
    endfunction

    function automatic logic [8:0] v_frz(bit busy);
        return pk(0, 0, 0, 0, 0, 0, busy, 2'd3);
    endfunction

    localparam logic [8:0] V_ZERO = 9'd0;

    task automatic push(input string tag, input bit inst_b, input logic [8:0] e);
        exp_t x;
        x.tag = tag; x.inst_b = inst_b; x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic check_q();
        exp_t       x;
        logic [8:0] o;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            o = x.inst_b ? obs_b : obs_a;
            tests++;
            assert (o === x.exp) else begin
                failed++;
                $error("FAIL %s observed=%b expected=%b", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic chk();
        @(negedge clk);
        check_q();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; exe_GPR_waddr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo_dep = 1'b0;
        exe_is_load = 1'b0; exe_div_start = 1'b0; mem_dmem_access = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Reset state
        push("reset_a", 0, V_ZERO);
        push("reset_b", 1, V_ZERO);
        chk();
        adv();
        reset = 1'b0;
        push("post_reset_a", 0, v_run(0));
        push("post_reset_b", 1, v_run(0));
        chk(); adv();

        // Load-use on rt
        exe_is_load = 1'b1; exe_GPR_waddr = 5'd8; id_uses_rt = 1'b1; id_rt_addr = 5'd8;
        push("lu_rt", 0, v_stall(2'd1, 0));
        chk(); adv();
        // Same match on r0 never stalls
        exe_GPR_waddr = 5'd0; id_rt_addr = 5'd0;
        push("lu_r0", 0, v_run(0));
        chk(); adv();
        // Load-use on rs
        idle();
        exe_is_load = 1'b1; exe_GPR_waddr = 5'd5; id_uses_rs = 1'b1; id_rs_addr = 5'd5;
        push("lu_rs", 0, v_stall(2'd1, 0));
        chk(); adv();
        // Address matches but the field is not read
        id_uses_rs = 1'b0;
        push("lu_unused", 0, v_run(0));
        chk(); adv();
        idle();

        // Held DMEM access on u_a: 2 off, 1 on, repeated
        mem_dmem_access = 1'b1;
        push("mw_frz0", 0, v_frz(0)); chk(); adv();
        push("mw_frz1", 0, v_frz(0)); chk(); adv();
        push("mw_rel0", 0, v_run(0)); chk(); adv();
        push("mw_frz2", 0, v_frz(0)); chk(); adv();
        push("mw_frz3", 0, v_frz(0)); chk(); adv();
        push("mw_rel1", 0, v_run(0)); chk(); adv();
        idle();

        // Divide followed by a held HI/LO dependent in ID
        exe_div_start = 1'b1;
        push("div_start", 0, v_run(0)); chk(); adv();
        exe_div_start = 1'b0; id_hilo_dep = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("hl_stall%0d", i), 0, v_stall(2'd2, 1));
            chk(); adv();
        end
        push("hl_release", 0, v_run(0)); chk(); adv();
        idle();

        // A div frozen in EXE by a mem wait must not start the divider
        mem_dmem_access = 1'b1; exe_div_start = 1'b1;
        push("frz_div_a0", 0, v_frz(0)); chk(); adv();
        idle();
        push("frz_div_a1", 0, v_frz(0)); chk(); adv();
        push("frz_div_a2", 0, v_run(0)); chk(); adv();

        // All three hazards together
        exe_div_start = 1'b1;
        push("combo_div_b", 1, v_run(0)); chk(); adv();
        exe_div_start = 1'b0;
        exe_is_load = 1'b1; exe_GPR_waddr = 5'd8; id_uses_rt = 1'b1; id_rt_addr = 5'd8;
        id_hilo_dep = 1'b1; mem_dmem_access = 1'b1;
        push("combo_b_mw", 1, v_frz(1));
        push("combo_a_mw", 0, v_frz(1));
        chk(); adv();
        push("combo_b_lu", 1, v_stall(2'd1, 1));
        push("combo_a_mw2", 0, v_frz(1));
        chk();

        // Reset mid-MEM_WAIT with the divider at 3
        reset = 1'b1;
        #1;
        push("midreset_a", 0, V_ZERO);
        push("midreset_b", 1, V_ZERO);
        check_q();
        adv();
        reset = 1'b0;
        idle();
        push("after_reset_a", 0, v_run(0));
        push("after_reset_b", 1, v_run(0));
        chk(); adv();
        mem_dmem_access = 1'b1;
        push("after_reset_mw_a", 0, v_frz(0));
        chk(); adv();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
